// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state type and status helper for the SPI flash responder.
package spi_flash_pkg;

   localparam logic [7:0] CmdRead = 8'h03;
   localparam logic [7:0] CmdProg = 8'h02;
   localparam logic [7:0] CmdWren = 8'h06;
   localparam logic [7:0] CmdWrdi = 8'h04;
   localparam logic [7:0] CmdRdsr = 8'h05;
   localparam logic [7:0] CmdRdid = 8'h9F;

   localparam int StatWelBit = 1;
   localparam int PageBytes  = 256;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_ID, ST_STAT, ST_PROG, ST_IGNORE
   } spi_flash_state_e;

   // WIP is always 0: programming completes in a single clock.
   function automatic logic [7:0] stat_byte(input logic wel);
      stat_byte = 8'h00;
      stat_byte[StatWelBit] = wel;
   endfunction

endpackage

// File: rtl/spi_flash_sync.sv
// Two-flop synchronizers for sck/cs_n/copi plus edge pulses on the synchronized sck and cs_n.
module spi_flash_sync
   import spi_flash_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic cs_n,
   input  logic copi,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_rise,
   output logic cs_fall,
   output logic cs_n_s,
   output logic copi_s
);

   logic [1:0] sck_ff, cs_ff, copi_ff;
   logic       sck_q, cs_q;

   // Reset to the idle bus state so releasing reset never fakes an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_ff  <= 2'b00;
         cs_ff   <= 2'b11;
         copi_ff <= 2'b00;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
      end else begin
         sck_ff  <= {sck_ff[0], sck};
         cs_ff   <= {cs_ff[0], cs_n};
         copi_ff <= {copi_ff[0], copi};
         sck_q   <= sck_ff[1];
         cs_q    <= cs_ff[1];
      end
   end

   assign sck_rise = sck_ff[1] & ~sck_q;
   assign sck_fall = ~sck_ff[1] & sck_q;
   assign cs_rise  = cs_ff[1] & ~cs_q;
   assign cs_fall  = ~cs_ff[1] & cs_q;
   assign cs_n_s   = cs_ff[1];
   assign copi_s   = copi_ff[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder serving READ/RDID/RDSR from a backdoor-loaded byte array.
// Define SPI_FLASH_PROGRAM_EN to add WREN/WRDI/page-program support.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int          MemBytes = 4096,
   parameter logic [23:0] JedecId  = 24'hEF4016,
   localparam int         AddrW    = $clog2(MemBytes)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sck_i,
   input  logic             cs_ni,
   input  logic             copi_i,
   output logic             cipo_o,
   input  logic             init_we_i,
   input  logic [AddrW-1:0] init_addr_i,
   input  logic [7:0]       init_data_i,
   output logic             busy_o
);

   logic sck_rise, sck_fall, cs_rise, cs_fall, cs_n_s, copi_s;

   spi_flash_sync u_sync (
      .clk(clk_i), .rst(rst_i), .sck(sck_i), .cs_n(cs_ni), .copi(copi_i),
      .sck_rise(sck_rise), .sck_fall(sck_fall), .cs_rise(cs_rise),
      .cs_fall(cs_fall), .cs_n_s(cs_n_s), .copi_s(copi_s)
   );

   spi_flash_state_e state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [AddrW-2:0] sh_q;
   logic [7:0]       op_q, op_d, tx_q, tx_d, rx_byte;
   logic [AddrW-1:0] addr_q, addr_d, addr_inc, rx_addr;
   logic [1:0]       id_q, id_d;
   logic             cipo_q, wel_q, byte_done;
   logic [7:0]       mem [MemBytes];

   // The shift register keeps only the address bits that survive truncation.
   assign rx_addr   = {sh_q, copi_s};
   assign rx_byte   = {sh_q[6:0], copi_s};
   assign addr_inc  = addr_q + AddrW'(1);
   assign byte_done = (cnt_q == 5'd7);

`ifdef SPI_FLASH_PROGRAM_EN
   localparam int PgW = $clog2(PageBytes);
   logic       wel_d, pseen_q, pseen_d, prog_we;
   logic [7:0] prog_data;
`else
   logic unused_cs_rise;
   assign unused_cs_rise = cs_rise;
   assign wel_q = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      tx_d    = tx_q;
      addr_d  = addr_q;
      id_d    = id_q;
`ifdef SPI_FLASH_PROGRAM_EN
      wel_d     = wel_q;
      pseen_d   = pseen_q;
      prog_we   = 1'b0;
      prog_data = mem[addr_q] & rx_byte;
`endif
      if (sck_fall) tx_d = {tx_q[6:0], 1'b0};
      if (cs_n_s) begin
         state_d = ST_IDLE;
`ifdef SPI_FLASH_PROGRAM_EN
         if (cs_rise && pseen_q) begin
            wel_d   = 1'b0;
            pseen_d = 1'b0;
         end
`endif
      end else if (state_q == ST_IDLE) begin
         if (cs_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
         end
      end else if (sck_rise) begin
         cnt_d = cnt_q + 5'd1;
         case (state_q)
            ST_CMD: if (byte_done) begin
               cnt_d   = '0;
               op_d    = rx_byte;
               state_d = ST_IGNORE;
               case (rx_byte)
                  CmdRead: state_d = ST_ADDR;
                  CmdRdid: begin
                     state_d = ST_ID;
                     tx_d    = JedecId[23:16];
                     id_d    = 2'd1;
                  end
                  CmdRdsr: begin
                     state_d = ST_STAT;
                     tx_d    = stat_byte(wel_q);
                  end
`ifdef SPI_FLASH_PROGRAM_EN
                  CmdWren: wel_d = 1'b1;
                  CmdWrdi: wel_d = 1'b0;
                  CmdProg: begin
                     state_d = ST_ADDR;
                     pseen_d = 1'b1;
                  end
`endif
                  default: ;
               endcase
            end
            ST_ADDR: if (cnt_q == 5'd23) begin
               cnt_d   = '0;
               addr_d  = rx_addr;
               state_d = ST_IGNORE;
               if (op_q == CmdRead) begin
                  state_d = ST_READ;
                  tx_d    = mem[rx_addr];
               end
`ifdef SPI_FLASH_PROGRAM_EN
               else if (wel_q) state_d = ST_PROG;
`endif
            end
            ST_READ: if (byte_done) begin
               cnt_d  = '0;
               addr_d = addr_inc;
               tx_d   = mem[addr_inc];
            end
            ST_ID: if (byte_done) begin
               cnt_d = '0;
               tx_d  = (id_q == 2'd1) ? JedecId[15:8] :
                       (id_q == 2'd2) ? JedecId[7:0]  : 8'h00;
               if (id_q != 2'd3) id_d = id_q + 2'd1;
            end
            ST_STAT: if (byte_done) begin
               cnt_d = '0;
               tx_d  = stat_byte(wel_q);
            end
`ifdef SPI_FLASH_PROGRAM_EN
            ST_PROG: if (byte_done) begin
               cnt_d   = '0;
               prog_we = 1'b1;
               addr_d  = {addr_q[AddrW-1:PgW], addr_q[PgW-1:0] + PgW'(1)};
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         op_q    <= '0;
         tx_q    <= '0;
         addr_q  <= '0;
         id_q    <= '0;
         cipo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         tx_q    <= tx_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         if (sck_rise) sh_q <= rx_addr[AddrW-2:0];
         if (!(state_d inside {ST_READ, ST_ID, ST_STAT})) cipo_q <= 1'b0;
         else if (sck_fall)                              cipo_q <= tx_q[7];
      end
   end

`ifdef SPI_FLASH_PROGRAM_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wel_q   <= 1'b0;
         pseen_q <= 1'b0;
      end else begin
         wel_q   <= wel_d;
         pseen_q <= pseen_d;
      end
   end
`endif

   // Backdoor write is last so it wins a same-address collision.
   always_ff @(posedge clk_i) begin
`ifdef SPI_FLASH_PROGRAM_EN
      if (prog_we) mem[addr_q] <= prog_data;
`endif
      if (init_we_i) mem[init_addr_i] <= init_data_i;
   end

   assign cipo_o = cipo_q;
   assign busy_o = ~cs_n_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: directed vector table, corner-case sequences, then random traffic vs a byte-array model.
`timescale 1ns/1ps
module tb_spi_flash_responder;
   import spi_flash_pkg::*;

   localparam int MemBytes = 4096;
   localparam int AddrW    = 12;
   localparam int HALF     = 5;
`ifdef SPI_FLASH_PROGRAM_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs_n = 1'b1, copi = 1'b0;
   logic cipo, busy, init_we = 1'b0;
   logic [AddrW-1:0] init_addr = '0;
   logic [7:0] init_data = '0;
   int checks = 0, errors = 0;

   logic [7:0] model_mem [MemBytes];
   logic       model_wel = 1'b0;
   logic [7:0] wbuf [16];
   logic [7:0] rbuf [16];

   typedef struct {
      logic [7:0]  op;
      bit          use_addr;
      logic [23:0] addr;
      int          n;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [7];

   always #5 clk = ~clk;

   spi_flash_responder #(.MemBytes(MemBytes), .JedecId(24'hEF4016)) dut (
      .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_ni(cs_n), .copi_i(copi),
      .cipo_o(cipo), .init_we_i(init_we), .init_addr_i(init_addr),
      .init_data_i(init_data), .busy_o(busy)
   );

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic bits(input logic [7:0] d, input int n, output logic [7:0] q);
      q = '0;
      for (int i = 7; i >= 8 - n; i--) begin
         copi = d[i];
         repeat (HALF) @(negedge clk);
         q[i] = cipo;
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] d, output logic [7:0] q);
      bits(d, 8, q);
   endtask

   task automatic cs_lo();
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_hi();
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      copi = 1'b0;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic txn(input logic [7:0] op, input bit use_addr, input logic [23:0] a, input int n);
      logic [7:0] q;
      cs_lo();
      xfer(op, q);
      check("cipo_cmd", q, 8'h00);
      if (use_addr) begin
         for (int b = 2; b >= 0; b--) begin
            xfer(a[8*b +: 8], q);
            check("cipo_addr", q, 8'h00);
         end
      end
      for (int i = 0; i < n; i++) begin
         xfer(wbuf[i], q);
         rbuf[i] = q;
      end
      cs_hi();
   endtask

   task automatic bd(input logic [AddrW-1:0] a, input logic [7:0] d);
      init_addr = a;
      init_data = d;
      init_we   = 1'b1;
      @(negedge clk);
      init_we   = 1'b0;
      model_mem[a] = d;
   endtask

   function automatic logic [7:0] id_byte(input int i);
      case (i)
         0: id_byte = 8'hEF;
         1: id_byte = 8'h40;
         2: id_byte = 8'h16;
         default: id_byte = 8'h00;
      endcase
   endfunction

   // Page program: AND each byte in, offset within a 256-byte page wraps.
   function automatic void m_prog(input logic [23:0] a, input int n);
      logic [AddrW-1:0] p;
      p = a[AddrW-1:0];
      if (model_wel) begin
         for (int i = 0; i < n; i++) begin
            model_mem[p] = model_mem[p] & wbuf[i];
            p[7:0] = p[7:0] + 8'd1;
         end
      end
      model_wel = 1'b0;
   endfunction

   initial begin
      logic [7:0] q, op;
      logic [23:0] a;
      int k, kind, n, idx;

      vecs[0] = '{8'h03, 1'b1, 24'h000010, 4, 32'h11223344};
      vecs[1] = '{8'h9F, 1'b0, 24'h000000, 4, 32'hEF401600};
      vecs[2] = '{8'h03, 1'b1, 24'h000FFF, 2, 32'hAABB0000};
      vecs[3] = '{8'h03, 1'b1, 24'h7F1011, 3, 32'h22334400};
      vecs[4] = '{8'h05, 1'b0, 24'h000000, 2, 32'h00000000};
      vecs[5] = '{8'hAB, 1'b0, 24'h000000, 2, 32'h00000000};
      vecs[6] = '{8'h03, 1'b1, 24'h000013, 1, 32'h44000000};
      for (int i = 0; i < 16; i++) wbuf[i] = 8'h5A;

      repeat (3) @(negedge clk);
      check("rst_cipo", {7'b0, cipo}, 8'h00);
      check("rst_busy", {7'b0, busy}, 8'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_busy", {7'b0, busy}, 8'h00);

      cs_n = 1'b0;
      @(negedge clk);
      check("busy_lat1", {7'b0, busy}, 8'h00);
      @(negedge clk);
      check("busy_lat2", {7'b0, busy}, 8'h01);
      cs_hi();
      check("busy_release", {7'b0, busy}, 8'h00);

      bd(12'h010, 8'h11); bd(12'h011, 8'h22); bd(12'h012, 8'h33); bd(12'h013, 8'h44);
      bd(12'hFFF, 8'hAA); bd(12'h000, 8'hBB); bd(12'h100, 8'hFF); bd(12'h1FF, 8'hFF);

      for (int v = 0; v < 7; v++) begin
         txn(vecs[v].op, vecs[v].use_addr, vecs[v].addr, vecs[v].n);
         for (int i = 0; i < vecs[v].n; i++)
            check($sformatf("vec%0d_byte%0d", v, i), rbuf[i], vecs[v].exp[31-8*i -: 8]);
      end

      wbuf[0] = 8'hF0;
      txn(CmdProg, 1'b1, 24'h000100, 1);
      txn(CmdRead, 1'b1, 24'h000100, 1);
      check("prog_no_wel", rbuf[0], 8'hFF);
      txn(CmdRdsr, 1'b0, 24'h0, 1);
      check("stat_rejected", rbuf[0], 8'h00);
      txn(CmdWren, 1'b0, 24'h0, 0);
      txn(CmdRdsr, 1'b0, 24'h0, 2);
      check("stat_wren0", rbuf[0], PE ? 8'h02 : 8'h00);
      check("stat_wren1", rbuf[1], PE ? 8'h02 : 8'h00);
      wbuf[0] = 8'h0F; wbuf[1] = 8'h3C;
      txn(CmdProg, 1'b1, 24'h0001FF, 2);
      txn(CmdRead, 1'b1, 24'h0001FF, 1);
      check("prog_1ff", rbuf[0], PE ? 8'h0F : 8'hFF);
      txn(CmdRead, 1'b1, 24'h000100, 1);
      check("prog_page_wrap", rbuf[0], PE ? 8'h3C : 8'hFF);
      txn(CmdRdsr, 1'b0, 24'h0, 1);
      check("stat_after_prog", rbuf[0], 8'h00);

      // Abort a program data byte halfway through.
      txn(CmdWren, 1'b0, 24'h0, 0);
      cs_lo();
      xfer(CmdProg, q); xfer(8'h00, q); xfer(8'h01, q); xfer(8'h00, q);
      bits(8'h00, 4, q);
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      k = 0;
      while (busy && k < 3) begin
         @(negedge clk);
         k++;
      end
      check("busy_fall", {7'b0, busy}, 8'h00);
      repeat (2 * HALF) @(negedge clk);
      txn(CmdRead, 1'b1, 24'h000100, 1);
      check("abort_no_write", rbuf[0], PE ? 8'h3C : 8'hFF);
      txn(CmdRdsr, 1'b0, 24'h0, 1);
      check("abort_wel_clr", rbuf[0], 8'h00);

      // Reset in the middle of a read of 0x33.
      cs_lo();
      xfer(CmdRead, q); xfer(8'h00, q); xfer(8'h00, q); xfer(8'h12, q);
      bits(8'h00, 3, q);
      check("midread_bits", q, 8'h20);
      repeat (HALF) @(negedge clk);
      check("midread_cipo", {7'b0, cipo}, 8'h01);
      rst = 1'b1;
      cs_n = 1'b1;
      @(negedge clk);
      check("midrst_cipo", {7'b0, cipo}, 8'h00);
      check("midrst_busy", {7'b0, busy}, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2 * HALF) @(negedge clk);
      txn(CmdRead, 1'b1, 24'h000010, 4);
      check("post_rst0", rbuf[0], 8'h11);
      check("post_rst1", rbuf[1], 8'h22);
      check("post_rst2", rbuf[2], 8'h33);
      check("post_rst3", rbuf[3], 8'h44);

      // Random traffic against the model.
      for (int i = 0; i < MemBytes; i++) bd(AddrW'(i), 8'($urandom));
      model_wel = 1'b0;
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 7);
         a = 24'($urandom);
         if (kind <= 2) begin
            n = $urandom_range(1, 6);
            txn(CmdRead, 1'b1, a, n);
            for (int i = 0; i < n; i++) begin
               idx = (int'(a[AddrW-1:0]) + i) % MemBytes;
               check($sformatf("rnd_read_%0d_%0d", t, i), rbuf[i], model_mem[idx]);
            end
         end else if (kind == 3) begin
            n = $urandom_range(1, 5);
            txn(CmdRdid, 1'b0, 24'h0, n);
            for (int i = 0; i < n; i++)
               check($sformatf("rnd_id_%0d_%0d", t, i), rbuf[i], id_byte(i));
         end else if (kind == 4) begin
            n = $urandom_range(1, 3);
            txn(CmdRdsr, 1'b0, 24'h0, n);
            for (int i = 0; i < n; i++)
               check($sformatf("rnd_stat_%0d_%0d", t, i), rbuf[i], {6'b0, model_wel, 1'b0});
         end else if (kind == 5) begin
            op = ($urandom_range(0, 1) == 1) ? CmdWren : CmdWrdi;
            txn(op, 1'b0, 24'h0, 0);
            model_wel = PE && (op == CmdWren);
         end else if (kind == 6) begin
            if ($urandom_range(0, 1) == 1) begin
               txn(CmdWren, 1'b0, 24'h0, 0);
               model_wel = PE;
            end
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            txn(CmdProg, 1'b1, a, n);
            m_prog(a, n);
         end else begin
            bd(a[AddrW-1:0], 8'($urandom));
            txn(8'hAB, 1'b0, 24'h0, 2);
            check($sformatf("rnd_unknown_%0d", t), rbuf[0] | rbuf[1], 8'h00);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
